// File: rtl/bus_stream_checker_pkg.sv
// Shared definitions for the RPI bus stream checker: FSM encodings,
// report word layout and status LED bit positions.
package bus_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int unsigned REPORT_WORDS = 5;

  localparam logic [2:0] RW_PASS     = 3'd0;
  localparam logic [2:0] RW_ERR_LO   = 3'd1;
  localparam logic [2:0] RW_ERR_HI   = 3'd2;
  localparam logic [2:0] RW_FIRST_LO = 3'd3;
  localparam logic [2:0] RW_FIRST_HI = 3'd4;

  localparam int unsigned LED_PASS    = 0;
  localparam int unsigned LED_DONE    = 1;
  localparam int unsigned LED_TIMEOUT = 2;
  localparam int unsigned LED_PROTO   = 3;

endpackage

// File: rtl/bus_strobe_sync.sv
// Brings the asynchronous RPI strobe, direction and data into the clk_100mhz
// domain and produces single-cycle write/read strobes on the rising edge.
module bus_strobe_sync #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic                  bus_clk,
  input  logic                  bus_rnw,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic                  wstrobe,
  output logic                  rstrobe,
  output logic [DATA_WIDTH-1:0] data_q
);

  logic [1:0]            clk_sync;
  logic [1:0]            rnw_sync;
  logic                  clk_prev;
  logic [DATA_WIDTH-1:0] data_s1;
  logic                  rise;

  // Data takes the same two-stage path as the strobe so both line up.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      rnw_sync <= '0;
      clk_prev <= 1'b0;
      data_s1  <= '0;
      data_q   <= '0;
    end else begin
      clk_sync <= {clk_sync[0], bus_clk};
      rnw_sync <= {rnw_sync[0], bus_rnw};
      clk_prev <= clk_sync[1];
      data_s1  <= bus_data_in;
      data_q   <= data_s1;
    end
  end

  assign rise    = clk_sync[1] & ~clk_prev;
  assign wstrobe = rise & ~rnw_sync[1];
  assign rstrobe = rise & rnw_sync[1];

endmodule

// File: rtl/bus_stream_checker.sv
// Receive-path checker for the RPI parallel bus: verifies a burst against an
// incrementing or LFSR pattern and returns a five-word result report.
module bus_stream_checker
  import bus_stream_checker_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH     = 8,
  parameter int unsigned          NUM_WORDS      = 256,
  parameter logic [DATA_WIDTH-1:0] SEED          = '0,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY     = DATA_WIDTH'(8'hB8),
  parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic                  bus_clk,
  input  logic                  bus_rnw,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  input  logic                  pattern_mode,
  output logic [3:0]            led_out,
  output logic                  done,
  output logic [15:0]           err_count
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

  state_t                state;
  logic                  wstrobe;
  logic                  rstrobe;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [DATA_WIDTH-1:0] cur_exp;
  logic                  mode_q;
  logic [15:0]           idx;
  logic [15:0]           first_err;
  logic [2:0]            rp;
  logic [TW-1:0]         idle_cnt;
  logic                  mismatch;
  logic                  pass;
  logic [DATA_WIDTH-1:0] report_word;

  function automatic logic [DATA_WIDTH-1:0] next_exp(input logic [DATA_WIDTH-1:0] cur,
                                                     input logic mode);
    if (!mode)       return cur + DATA_WIDTH'(1);
    else if (cur[0]) return (cur >> 1) ^ LFSR_POLY;
    else             return cur >> 1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] seed_for(input logic mode);
    return (mode && (SEED == '0)) ? DATA_WIDTH'(1) : SEED;
  endfunction

  bus_strobe_sync #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
    .clk_100mhz  (clk_100mhz),
    .reset       (reset),
    .bus_clk     (bus_clk),
    .bus_rnw     (bus_rnw),
    .bus_data_in (bus_data_in),
    .wstrobe     (wstrobe),
    .rstrobe     (rstrobe),
    .data_q      (data_q)
  );

  assign bus_data_oe = bus_rnw;
  assign pass        = (err_count == '0);
  // Word 0 is compared against the seed for the mode being latched this cycle.
  assign cur_exp     = (state == ST_IDLE) ? seed_for(pattern_mode) : exp_word;
  assign mismatch    = (data_q != cur_exp);

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      exp_word  <= '0;
      mode_q    <= 1'b0;
      idx       <= '0;
      err_count <= '0;
      first_err <= '1;
      rp        <= '0;
      idle_cnt  <= '0;
      led_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (wstrobe) begin
            mode_q    <= pattern_mode;
            exp_word  <= next_exp(cur_exp, pattern_mode);
            idx       <= 16'd1;
            err_count <= mismatch ? 16'd1 : '0;
            first_err <= mismatch ? '0 : '1;
            rp        <= '0;
            state     <= (NUM_WORDS == 1) ? ST_REPORT : ST_RECV;
          end
        end
        ST_RECV: begin
          if (wstrobe || rstrobe) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            led_out[LED_TIMEOUT] <= 1'b1;
            state                <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
          if (rstrobe) led_out[LED_PROTO] <= 1'b1;
          if (wstrobe) begin
            exp_word <= next_exp(exp_word, mode_q);
            idx      <= idx + 16'd1;
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + 16'd1;
              if (err_count == '0) first_err <= idx;
            end
            if (idx == LAST_IDX) begin
              rp    <= '0;
              state <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          if (wstrobe) led_out[LED_PROTO] <= 1'b1;
          if (rstrobe) begin
            if (rp == RW_FIRST_HI) begin
              done              <= 1'b1;
              led_out[LED_PASS] <= pass;
              led_out[LED_DONE] <= 1'b1;
              state             <= ST_IDLE;
            end else begin
              rp <= rp + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    report_word = '0;
    if (state == ST_REPORT) begin
      case (rp)
        RW_PASS:     report_word = DATA_WIDTH'(pass);
        RW_ERR_LO:   report_word = DATA_WIDTH'(err_count[7:0]);
        RW_ERR_HI:   report_word = DATA_WIDTH'(err_count[15:8]);
        RW_FIRST_LO: report_word = DATA_WIDTH'(first_err[7:0]);
        RW_FIRST_HI: report_word = DATA_WIDTH'(first_err[15:8]);
        default:     report_word = '0;
      endcase
    end
  end

  assign bus_data_out = report_word;

endmodule

// File: tb/tb_bus_stream_checker.sv
// Randomised scoreboard bench for bus_stream_checker driving the RPI bus pins.
module tb_bus_stream_checker;

  localparam int unsigned NW = 256;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } sb_t;

  logic       clk_100mhz = 1'b0;
  logic       reset      = 1'b1;
  logic       bus_clk    = 1'b0;
  logic       bus_rnw    = 1'b0;
  logic [7:0] bus_data_in = '0;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic       pattern_mode = 1'b0;
  logic [3:0] led_out;
  logic       done;
  logic [15:0] err_count;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic [3:0] led_model = '0;
  sb_t  sb_q[$];
  logic [7:0] ref_seq[NW];
  logic [7:0] burst[NW];

  bus_stream_checker #(
    .DATA_WIDTH     (8),
    .NUM_WORDS      (NW),
    .SEED           (8'h00),
    .LFSR_POLY      (8'hB8),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .reset        (reset),
    .bus_clk      (bus_clk),
    .bus_rnw      (bus_rnw),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .pattern_mode (pattern_mode),
    .led_out      (led_out),
    .done         (done),
    .err_count    (err_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(negedge clk_100mhz) if (done === 1'b1) done_seen++;

  // Monitor: the report word is valid on the pins when the RPI raises bus_clk.
  always @(posedge bus_clk) begin
    if (bus_rnw) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %02h, required no read", bus_data_out);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (bus_data_out !== e.val) begin
            errors++;
            $display("FAIL report_word: got %02h, required %02h", bus_data_out, e.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic bus_write(input logic [7:0] d);
    @(negedge clk_100mhz);
    bus_rnw = 1'b0; bus_data_in = d;
    repeat (2) @(negedge clk_100mhz);
    bus_clk = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    bus_clk = 1'b0;
    repeat (6) @(negedge clk_100mhz);
  endtask

  task automatic bus_read(input logic chk, input logic [7:0] v);
    sb_t e;
    e.chk = chk; e.val = v;
    sb_q.push_back(e);
    @(negedge clk_100mhz);
    bus_rnw = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    bus_clk = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    bus_clk = 1'b0;
    repeat (6) @(negedge clk_100mhz);
  endtask

  // Pattern from the rules: mode 0 counts up from 0, mode 1 is a Galois LFSR from 1.
  task automatic make_ref(input logic mode);
    int unsigned x;
    x = mode ? 1 : 0;
    for (int i = 0; i < NW; i++) begin
      ref_seq[i] = 8'(x);
      if (!mode) x = (x + 1) % 256;
      else if (x % 2 == 1) x = (x / 2) ^ 32'hB8;
      else x = x / 2;
      burst[i] = ref_seq[i];
    end
  endtask

  task automatic send_words(input int from, input int to);
    for (int i = from; i < to; i++) bus_write(burst[i]);
  endtask

  task automatic report_words(output logic [7:0] w[5], output logic pass);
    int unsigned nerr;
    int unsigned first;
    nerr = 0; first = 32'hFFFF;
    for (int i = 0; i < NW; i++)
      if (burst[i] != ref_seq[i]) begin
        if (nerr == 0) first = i;
        nerr++;
      end
    pass = (nerr == 0);
    w[0] = pass ? 8'h01 : 8'h00;
    w[1] = 8'(nerr); w[2] = 8'(nerr >> 8);
    w[3] = 8'(first); w[4] = 8'(first >> 8);
  endtask

  task automatic read_report(input string tag);
    logic [7:0] w[5];
    logic pass;
    report_words(w, pass);
    check({tag, "_err_count"}, 32'(err_count), {24'h0, w[2], w[1]});
    for (int i = 0; i < 5; i++) bus_read(1'b1, w[i]);
    done_exp++;
    led_model[0] = pass; led_model[1] = 1'b1;
    check({tag, "_done_pulses"}, done_seen, done_exp);
    check({tag, "_led"}, 32'(led_out), 32'(led_model));
  endtask

  task automatic full_burst(input logic mode, input string tag);
    pattern_mode = mode;
    send_words(0, NW);
    read_report(tag);
  endtask

  task automatic random_corrupt(input int max_errs);
    int n;
    n = $urandom_range(max_errs, 0);
    for (int k = 0; k < n; k++) begin
      int p;
      p = $urandom_range(NW - 1, 0);
      burst[p] = ref_seq[p] ^ 8'($urandom_range(255, 1));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk_100mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check("reset_data_out", 32'(bus_data_out), 0);
    check("reset_led", 32'(led_out), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err_count", 32'(err_count), 0);

    make_ref(1'b0);
    full_burst(1'b0, "inc_clean");

    make_ref(1'b0);
    burst[10] = 8'h55; burst[200] = 8'h00;
    full_burst(1'b0, "inc_two_errs");

    make_ref(1'b1);
    full_burst(1'b1, "lfsr_clean");

    make_ref(1'b0);
    pattern_mode = 1'b0;
    send_words(0, 100);
    repeat (300) @(negedge clk_100mhz);
    led_model[2] = 1'b1;
    check("timeout_led", 32'(led_out), 32'(led_model));
    full_burst(1'b0, "after_timeout");

    make_ref(1'b1);
    pattern_mode = 1'b1;
    send_words(0, 50);
    bus_read(1'b0, 8'h00);
    led_model[3] = 1'b1;
    check("proto_led", 32'(led_out), 32'(led_model));
    send_words(50, NW);
    read_report("mid_read");

    for (int r = 0; r < 3; r++) begin
      logic m;
      m = 1'($urandom_range(1, 0));
      make_ref(m);
      random_corrupt(4);
      full_burst(m, "random");
    end

    begin
      logic [7:0] w[5];
      logic pass;
      make_ref(1'b0);
      random_corrupt(3);
      burst[7] = ~ref_seq[7];
      pattern_mode = 1'b0;
      send_words(0, NW);
      report_words(w, pass);
      bus_read(1'b1, w[0]);
      bus_read(1'b1, w[1]);
      @(negedge clk_100mhz);
      reset = 1'b1;
      #1;
      check("rst_report_data_out", 32'(bus_data_out), 0);
      check("rst_report_led", 32'(led_out), 0);
      check("rst_report_done", 32'(done), 0);
      check("rst_report_err_count", 32'(err_count), 0);
      repeat (3) @(negedge clk_100mhz);
      reset = 1'b0;
      led_model = '0;
      repeat (3) @(negedge clk_100mhz);
    end

    make_ref(1'b1);
    random_corrupt(4);
    full_burst(1'b1, "after_reset");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_stream_checker.md
Name: bus_stream_checker

Overview:
- Parametrised receive-path checker for the RPI parallel bus; successor to the fixed 256-byte sequential data test.
- Synchronises the bus strobes, checks a burst of NUM_WORDS writes against a run-time-selected pattern (incrementing or LFSR), counts errors and records the first failing index.
- Returns a multi-word result report over bus reads. Sits directly behind the top-level tristate bus pins.

Parameters:
DATA_WIDTH, 8, bus data width; must be ≥8
NUM_WORDS, 256, words per burst; 1..65535
SEED, 0, first expected word in both modes (LFSR mode forces 1 if SEED==0)
LFSR_POLY, 8'hB8, Galois LFSR feedback mask, DATA_WIDTH bits
TIMEOUT_CYCLES, 1000000, idle clk cycles in RECV before abort

Ports:
clk_100mhz  input  1  system clock
reset  input  1  asynchronous active-high reset
bus_clk  input  1  RPI strobe, asynchronous
bus_rnw  input  1  1=RPI reads, 0=RPI writes
bus_data_in  input  DATA_WIDTH  bus pins, input path
bus_data_out  output  DATA_WIDTH  current report word
bus_data_oe  output  1  tristate enable; equals bus_rnw input combinationally
pattern_mode  input  1  0=incrementing, 1=LFSR; sampled on burst start
led_out  output  4  status LEDs
done  output  1  one-cycle pulse when report fully read
err_count  output  16  errors of last burst, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; bus_data_out=0, led_out=0, done=0, err_count=0; synchronisers cleared.
- bus_clk and bus_rnw pass a 2-flop synchroniser; bus_data_in is registered alongside so data and strobe align. A strobe is the rising edge of synchronised bus_clk, detected 3 clk cycles after the pin rises.
- Strobe types: wstrobe when synced rnw=0; rstrobe when synced rnw=1. RPI holds bus_clk high/low ≥4 clk cycles each.
- Expected generator:
  - Mode 0: exp+1, mod 2^DATA_WIDTH.
  - Mode 1: Galois shift; if exp[0], then (exp>>1)^LFSR_POLY, else exp>>1.
  - Loaded with SEED on burst start.
- States:
  - IDLE: on wstrobe, latch pattern_mode, compare word 0, idx=1, go RECV. rstrobe ignored.
  - RECV: each wstrobe compares data to exp and advances exp and idx.
    - On mismatch: err_count += 1, saturating at 16'hFFFF. If it is the first mismatch, first_err = index.
    - When idx reaches NUM_WORDS after a compare, go REPORT.
    - rstrobe in RECV: set led_out[3] (sticky protocol error), otherwise ignored.
    - No strobe for TIMEOUT_CYCLES: set led_out[2] (sticky), go IDLE, discard burst.
  - REPORT: word pointer rp=0 on entry; bus_data_out valid on the entry cycle.
    - Words: 0 = pass (1 if err_count==0, else 0), zero-extended; 1 = err_count[7:0]; 2 = err_count[15:8]; 3 = first_err[7:0]; 4 = first_err[15:8].
    - first_err is 16'hFFFF when there were no errors.
    - Each rstrobe advances rp; bus_data_out updates the next cycle.
    - The rstrobe for word 4 goes to IDLE, pulses done for one cycle and sets led_out[0]=pass, led_out[1]=1.
    - wstrobe in REPORT: set led_out[3], stay in REPORT.
- err_count and first_err hold until the next burst starts (the IDLE wstrobe clears them before that compare).
- NUM_WORDS=1: the IDLE compare goes straight to REPORT.
- Timeout counter resets on every strobe; it is only active in RECV.

Decomposition:
- Shared package: state encodings (IDLE/RECV/REPORT), report word indices, REPORT_WORDS=5, LED bit positions.
- One sub-module: bus_strobe_sync (2-flop sync of bus_clk/bus_rnw plus data register and edge detect; outputs wstrobe, rstrobe, data_q). Reused by later bus blocks.

Test Plan:
- Mode 0, SEED 0, 256 writes of 0..255, then 5 reads -> reads 1,0,0,FF,FF; led_out=4'b0011; done pulses once.
- Mode 0, word 10 written as 0x55 and word 200 as 0x00 -> reads 0,2,0,10,0; led_out[0]=0.
- Mode 1, SEED 1, POLY B8: first five writes 01,B8,5C,2E,17, continuing the sequence for all 256 words -> pass report.
- 100 writes, then bus_clk idle beyond TIMEOUT_CYCLES (bench override 200) -> IDLE, led_out[2]=1; the next full burst still passes.
- Read strobe mid-burst at word 50 -> led_out[3]=1; burst continues and reports pass.
- Reset asserted in REPORT after 2 reads -> all outputs 0 immediately; a fresh burst works.
